// File: rtl/cpu_reg_pkg.sv
// Register map, bit positions and shared types for the CPU register bank.
// Both the bank and its TX FIFO import this package.
package cpu_reg_pkg;

  typedef enum logic [7:0] {
    REG_ID      = 8'h00,
    REG_CTRL    = 8'h01,
    REG_STATUS  = 8'h02,
    REG_SCRATCH = 8'h03,
    REG_TX_DATA = 8'h04,
    REG_ERR_CNT = 8'h05
  } reg_addr_e;

  localparam int REG_WIDTH    = 32;
  localparam int DECODE_WIDTH = 8;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_LEVEL_LSB = 4;
  localparam int STATUS_LEVEL_W   = 4;

  localparam int ERR_CNT_W = 16;

  typedef logic [REG_WIDTH-1:0] reg_word_t;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic err_cnt_t sat_inc(input err_cnt_t value);
    return (value == '1) ? value : value + err_cnt_t'(1);
  endfunction

endpackage

// File: rtl/cpu_tx_fifo.sv
// TX word FIFO: power-of-two depth, wrapping pointers, level one bit wider
// than the pointers, synchronous flush, head forced to zero while empty.
module cpu_tx_fifo
  import cpu_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REG_WIDTH
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign full  = (count == LEVEL_W'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // Flush overrides any push or pop presented in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // NOTE: state registers use non-blocking assignments so every flop in the
  // block samples the values that existed before the clock edge.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries only become visible through
  // the level counter, and the head is masked to zero while the FIFO is empty.
  always_ff @(posedge iclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cpu_reg_bank.sv
// CPU-visible register bank: edge-detected bus strobes, ID/CTRL/STATUS/SCRATCH
// registers, saturating error counter and a TX FIFO drained by a valid/ready stream.
module cpu_reg_bank
  import cpu_reg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 256,
  parameter int          DATA_WIDTH = 256,
  parameter logic [31:0] BLOCK_ID   = 32'hC0DE_0001,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  iwr,
  input  logic                  ird,
  output logic [DATA_WIDTH-1:0] odata,
  output logic [31:0]           otx_data,
  output logic                  otx_valid,
  input  logic                  itx_ready
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                    wr_q;
  logic                    rd_q;
  logic                    wr_ev;
  logic                    rd_ev;
  logic                    collide;
  logic                    do_wr;
  logic                    do_rd;
  logic                    mapped;
  logic [DECODE_WIDTH-1:0] addr_lo;
  reg_word_t               wr_word;
  logic                    unused_idata_hi;

  logic                    en;
  reg_word_t               scratch;
  err_cnt_t                err_cnt;

  logic                    ctrl_we;
  logic                    scratch_we;
  logic                    wr_err;
  logic                    rd_err;
  logic                    err_inc;
  reg_word_t               rd_word;
  reg_word_t               status_word;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_flush;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [LEVEL_W-1:0]      fifo_level;
  reg_word_t               fifo_head;

  // Strobe history is cleared by reset, so a strobe held across release
  // counts as a fresh transaction on the first clock afterwards.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= iwr;
      rd_q <= ird;
    end
  end

  assign wr_ev   = iwr & ~wr_q;
  assign rd_ev   = ird & ~rd_q;
  assign collide = wr_ev & rd_ev;
  assign do_wr   = wr_ev & ~rd_ev;
  assign do_rd   = rd_ev & ~wr_ev;

  assign addr_lo         = iaddr[DECODE_WIDTH-1:0];
  assign mapped          = (iaddr[ADDR_WIDTH-1:DECODE_WIDTH] == '0);
  assign wr_word         = idata[REG_WIDTH-1:0];
  assign unused_idata_hi = ^idata[DATA_WIDTH-1:REG_WIDTH];

  always_comb begin
    status_word                                     = '0;
    status_word[STATUS_EMPTY_BIT]                   = fifo_empty;
    status_word[STATUS_FULL_BIT]                    = fifo_full;
    status_word[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = STATUS_LEVEL_W'(fifo_level);
  end

  // NOTE: every signal driven here is given a default before any branch, so
  // no path through the decode can leave one unassigned and infer a latch.
  always_comb begin
    ctrl_we    = 1'b0;
    scratch_we = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    wr_err     = 1'b0;
    if (do_wr) begin
      if (!mapped) begin
        wr_err = 1'b1;
      end else begin
        case (addr_lo)
          REG_CTRL: begin
            ctrl_we    = 1'b1;
            fifo_flush = wr_word[CTRL_CLR_BIT];
          end
          REG_SCRATCH: scratch_we = 1'b1;
          REG_TX_DATA: begin
            // A full FIFO drops the word even if a pop lands this same cycle.
            if (fifo_full) wr_err    = 1'b1;
            else           fifo_push = 1'b1;
          end
          default: wr_err = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    if (do_rd) begin
      if (!mapped) begin
        rd_err = 1'b1;
      end else begin
        case (addr_lo)
          REG_ID:      rd_word = BLOCK_ID;
          REG_CTRL:    rd_word[CTRL_EN_BIT] = en;
          REG_STATUS:  rd_word = status_word;
          REG_SCRATCH: rd_word = scratch;
          REG_TX_DATA: rd_word = '0;
          REG_ERR_CNT: rd_word = REG_WIDTH'(err_cnt);
          default:     rd_err  = 1'b1;
        endcase
      end
    end
  end

  assign err_inc = collide | wr_err | rd_err;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      en      <= 1'b0;
      scratch <= '0;
      err_cnt <= '0;
      odata   <= '0;
    end else begin
      if (ctrl_we)    en      <= wr_word[CTRL_EN_BIT];
      if (scratch_we) scratch <= wr_word;
      // CLR is a pulse: it zeroes the counter and flushes, but is never stored.
      if (fifo_flush)   err_cnt <= '0;
      else if (err_inc) err_cnt <= sat_inc(err_cnt);
      if (do_rd) odata <= DATA_WIDTH'(rd_word);
    end
  end

  assign otx_valid = ~fifo_empty & en;
  assign fifo_pop  = otx_valid & itx_ready;
  assign otx_data  = fifo_head;

  cpu_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REG_WIDTH)
  ) u_tx_fifo (
    .iclk      (iclk),
    .irst      (irst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .push_data (wr_word),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: doc/cpu_reg_bank.md
CPU_REG_BANK -- requirements
Module: cpu_reg_bank

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 256, CPU bus address width; DATA_WIDTH, default 256, CPU bus data width; BLOCK_ID, default 32'hC0DE_0001, value returned by the ID register; FIFO_DEPTH, default 4, TX FIFO depth as a power of two.
REQ-002 Port iclk SHALL be an input, 1 bit: the single clock.
REQ-003 Port irst SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 Port iaddr SHALL be an input, ADDR_WIDTH bits: the bus address from the CPU master.
REQ-005 Port idata SHALL be an input, DATA_WIDTH bits: the bus write data.
REQ-006 Port iwr SHALL be an input, 1 bit: write strobe, held high for several cycles per transaction.
REQ-007 Port ird SHALL be an input, 1 bit: read strobe, held high for several cycles per transaction.
REQ-008 Port odata SHALL be an output, DATA_WIDTH bits: registered read data returned to the master.
REQ-009 Port otx_data SHALL be an output, 32 bits: the TX stream data word (FIFO head).
REQ-010 Port otx_valid SHALL be an output, 1 bit: TX stream valid.
REQ-011 Port itx_ready SHALL be an input, 1 bit: TX stream ready from the consumer.

Function
REQ-012 The block SHALL act once per transaction, on the first cycle the strobe is high: iwr high with the previous-cycle iwr low is a write event; ird high with the previous-cycle ird low is a read event.
REQ-013 If write and read events occur in the same cycle, neither SHALL be performed and ERR_CNT SHALL increment.
REQ-014 Decode SHALL use iaddr[7:0]; any nonzero iaddr[ADDR_WIDTH-1:8] SHALL mark the access as unmapped.
REQ-015 Register map:
- 0x00 ID, read-only: BLOCK_ID.
- 0x01 CTRL, read/write: bit0 EN; bit1 CLR, which is self-clearing and always reads 0.
- 0x02 STATUS, read-only: bit0 empty; bit1 full; bits[7:4] FIFO level.
- 0x03 SCRATCH, read/write: 32 bits.
- 0x04 TX_DATA, write-only: pushes idata[31:0] into the FIFO; reads return 0.
- 0x05 ERR_CNT, read-only: 16-bit saturating error counter.
REQ-016 Only the low 32 bits of idata SHALL be stored; odata bits above 31 SHALL read 0.
REQ-017 odata SHALL update on the cycle after the read event and hold until the next read event; the master's read wait SHALL be at least 2 cycles.
REQ-018 A write or read to an unmapped address, or to a read-only register with a write, SHALL have no other effect; ERR_CNT SHALL increment, and an unmapped read SHALL return 0.
REQ-019 A TX_DATA write while the FIFO is full SHALL be dropped and ERR_CNT SHALL increment, even if a pop occurs in the same cycle.
REQ-020 otx_valid SHALL equal (not empty AND EN); otx_data SHALL be the FIFO head; a pop SHALL occur when otx_valid and itx_ready are both high.
REQ-021 A simultaneous push and pop with the FIFO neither empty nor full SHALL leave the level unchanged; a push into an empty FIFO SHALL raise otx_valid on the next cycle.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with the level counter one bit wider than the pointers.
REQ-023 A CTRL write with CLR=1 SHALL, in the same cycle, flush the FIFO (level 0, pointers 0) and zero ERR_CNT; EN SHALL take the written bit0.
REQ-024 ERR_CNT SHALL saturate at 16'hFFFF.

Reset
REQ-025 On irst low, the block SHALL immediately set: odata=0, CTRL=0, SCRATCH=0, ERR_CNT=0, FIFO empty with pointers 0, otx_valid=0, otx_data=0, and the strobe-history registers=0.
REQ-026 A strobe already high when irst deasserts SHALL be treated as a new event on the first clock after release.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no register or FIFO update.

Structure
REQ-028 Register addresses, CTRL/STATUS bit positions and the ERR_CNT width SHALL be constants in a shared package, cpu_reg_pkg.
REQ-029 The TX FIFO SHALL be a sub-module, cpu_tx_fifo, with push/pop/flush inputs, full/empty/level outputs and the same reset.

Verification
REQ-030 Bench scenario: write 0x03 = 0xA5A5_1234 with iwr held 6 cycles, then read 0x03 -> odata=0xA5A5_1234 one cycle after the read edge, with exactly one write performed.
REQ-031 Bench scenario: with EN=1 and itx_ready=0, push 5 words -> STATUS=0x42 (full, level 4), 5th word dropped, ERR_CNT=1; then itx_ready=1 -> the 4 words are popped in order.
REQ-032 Bench scenario: iwr and ird rise in the same cycle at 0x03 -> SCRATCH unchanged, ERR_CNT increments by 1.
REQ-033 Bench scenario: read iaddr=0x1_00 -> odata=0, ERR_CNT+1; write 0x00 -> ID still BLOCK_ID, ERR_CNT+1.
REQ-034 Bench scenario: FIFO at level 3, write CTRL=0x3 -> next cycle STATUS=0x01, ERR_CNT=0, CTRL reads 0x1.
REQ-035 Bench scenario: assert irst low mid-write to 0x04 -> FIFO empty, otx_valid=0, all registers reset immediately without a clock edge.
